// File: rtl/conv33_stream.sv
// conv33_stream: streaming 3x3 convolution (pass / sharpen / gauss / edge) over NUM_CH packed channels.
// Optional macro CONV33_SAT_CNT_EN adds the sat_cnt output counting clamped channel results.
module conv33_stream #(
  parameter int NUM_CH      = 3,
  parameter int PIXEL_WIDTH = 8,
  parameter int ACCW        = 16,
  parameter int IMG_W       = 640
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_sof,
  input  logic [NUM_CH*PIXEL_WIDTH-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sof,
  output logic [NUM_CH*PIXEL_WIDTH-1:0] out_data
`ifdef CONV33_SAT_CNT_EN
  ,
  output logic [15:0]                   sat_cnt
`endif
);

  localparam int DW = NUM_CH * PIXEL_WIDTH;
  localparam int CW = $clog2(IMG_W);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic signed [ACCW-1:0] PIX_MAX = ACCW'((1 << PIXEL_WIDTH) - 1);

  logic [DW-1:0]          lb0_r [IMG_W];
  logic [DW-1:0]          lb1_r [IMG_W];
  logic [DW-1:0]          win_r [3][3];
  logic [DW-1:0]          nxt_s [3][3];
  logic [CW-1:0]          col_r;
  logic [15:0]            row_r;
  logic [1:0]             mode_r;
  logic                   accept_s;
  logic                   emit_s;
  logic                   first_s;
  logic [CW-1:0]          cur_col_s;
  logic [15:0]            cur_row_s;
  logic signed [ACCW-1:0] acc_s [NUM_CH];
  logic [DW-1:0]          res_s;

  function automatic logic signed [ACCW-1:0] widen(input logic [PIXEL_WIDTH-1:0] p);
    return $signed(ACCW'(p));
  endfunction

  function automatic logic [PIXEL_WIDTH-1:0] clamp_pix(input logic signed [ACCW-1:0] v);
    logic [PIXEL_WIDTH-1:0] r;
    if (v[ACCW-1]) begin
      r = {PIXEL_WIDTH{1'b0}};
    end else if (v > PIX_MAX) begin
      r = {PIXEL_WIDTH{1'b1}};
    end else begin
      r = v[PIXEL_WIDTH-1:0];
    end
    return r;
  endfunction

  // Handshake decode and the window as it will look once this pixel shifts in
  always_comb begin
    in_ready  = !out_valid || out_ready;
    accept_s  = in_valid && in_ready;
    cur_col_s = in_sof ? {CW{1'b0}} : col_r;
    cur_row_s = in_sof ? 16'd0 : row_r;
    emit_s    = accept_s && (cur_row_s >= 16'd2) && (cur_col_s >= CW'(2));
    first_s   = (cur_row_s == 16'd2) && (cur_col_s == CW'(2));
    for (int r = 0; r < 3; r++) begin
      nxt_s[r][0] = win_r[r][1];
      nxt_s[r][1] = win_r[r][2];
    end
    nxt_s[0][2] = lb1_r[cur_col_s];
    nxt_s[1][2] = lb0_r[cur_col_s];
    nxt_s[2][2] = in_data;
  end

  // Per-channel kernel accumulation and clamp
  always_comb begin
    logic signed [ACCW-1:0] p [3][3];
    logic signed [ACCW-1:0] edges;
    logic signed [ACCW-1:0] corners;
    res_s = {DW{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          p[r][c] = widen(nxt_s[r][c][ch*PIXEL_WIDTH +: PIXEL_WIDTH]);
        end
      end
      edges   = p[0][1] + p[2][1] + p[1][0] + p[1][2];
      corners = p[0][0] + p[0][2] + p[2][0] + p[2][2];
      acc_s[ch] = {ACCW{1'b0}};
      case (mode_r)
        2'd0:    acc_s[ch] = p[1][1];
        2'd1:    acc_s[ch] = (p[1][1] <<< 2) + p[1][1] - edges;
        2'd2:    acc_s[ch] = (corners + (edges <<< 1) + (p[1][1] <<< 2)) >>> 4;
        2'd3:    acc_s[ch] = (p[1][1] <<< 3) - edges - corners;
        default: acc_s[ch] = p[1][1];
      endcase
      res_s[ch*PIXEL_WIDTH +: PIXEL_WIDTH] = clamp_pix(acc_s[ch]);
    end
  end

  // Position counters, frame-latched kernel select and the 3x3 window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_r  <= {CW{1'b0}};
      row_r  <= 16'd0;
      mode_r <= 2'd0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_r[r][c] <= {DW{1'b0}};
        end
      end
    end else if (accept_s) begin
      if (in_sof) begin
        mode_r <= mode;
      end
      if (cur_col_s == COL_LAST) begin
        col_r <= {CW{1'b0}};
        row_r <= (cur_row_s == 16'hFFFF) ? cur_row_s : cur_row_s + 16'd1;
      end else begin
        col_r <= cur_col_s + CW'(1);
        row_r <= cur_row_s;
      end
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_r[r][c] <= nxt_s[r][c];
        end
      end
    end
  end

  // Line buffers: lb0 holds the previous row, lb1 the one before it
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb1_r[cur_col_s] <= lb0_r[cur_col_s];
      lb0_r[cur_col_s] <= in_data;
    end
  end

  // Single output register; only loaded when in_ready admitted the pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_data  <= {DW{1'b0}};
    end else if (emit_s) begin
      out_valid <= 1'b1;
      out_sof   <= first_s;
      out_data  <= res_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
    end
  end

`ifdef CONV33_SAT_CNT_EN
  localparam int SW = $clog2(NUM_CH + 1);

  logic [SW-1:0] sat_n_s;
  logic [SW-1:0] sat_n_r;
  logic [16:0]   sat_sum_s;

  function automatic logic is_clamped(input logic signed [ACCW-1:0] v);
    return v[ACCW-1] || (v > PIX_MAX);
  endfunction

  // Clamp events in the result being loaded, and the saturating running total
  always_comb begin
    sat_n_s = {SW{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sat_n_s = sat_n_s + SW'(is_clamped(acc_s[ch]));
    end
    sat_sum_s = {1'b0, sat_cnt} + 17'(sat_n_r);
  end

  // Events are counted when their output is handed off; a new frame clears the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_n_r <= {SW{1'b0}};
      sat_cnt <= 16'd0;
    end else begin
      if (emit_s) begin
        sat_n_r <= sat_n_s;
      end
      if (accept_s && in_sof) begin
        sat_cnt <= 16'd0;
      end else if (out_valid && out_ready) begin
        sat_cnt <= sat_sum_s[16] ? 16'hFFFF : sat_sum_s[15:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv33_stream.sv
// Directed self-checking bench for conv33_stream with IMG_W=4, NUM_CH=3, 4x4 frames.
`timescale 1ns/1ps
module tb_conv33_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic        in_sof;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic [23:0] out_data;
`ifdef CONV33_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [23:0] q_data [$];
  logic        q_sof  [$];

  conv33_stream #(.NUM_CH(3), .PIXEL_WIDTH(8), .ACCW(16), .IMG_W(4)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_data(out_data)
`ifdef CONV33_SAT_CNT_EN
    , .sat_cnt(sat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Record every output handshake (committed at the following rising edge)
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_sof.push_back(out_sof);
    end
  end

  function automatic logic [23:0] pixel(input int kind, input int r, input int c);
    logic [7:0] v;
    case (kind)
      0: begin v = 8'(r * 4 + c + 1); return {v + 8'h80, v + 8'h40, v}; end
      1: return 24'h808080;
      2: return 24'h101010;
      3: return (r == 1 && c == 1) ? 24'hFFFFFF : 24'h000000;
      4: return (r == 1 && c == 1) ? 24'h000000 : 24'hFFFFFF;
      5: begin v = 8'(r * 4 + c + 16); return {v, v, v}; end
      default: return 24'h000000;
    endcase
  endfunction

  task automatic push(input logic [23:0] d, input logic s);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL push_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int kind, input logic [1:0] m, input int sw_row, input logic [1:0] m2);
    mode = m;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (r == sw_row && c == 0) mode = m2;
        push(pixel(kind, r, c), (r == 0 && c == 0));
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; mode = 2'd0; in_valid = 1'b0; in_sof = 1'b0; in_data = 24'h0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_sof !== 1'b0) $display("FAIL reset_sof: got %b want 0", out_sof); else n_pass++;
    n_checks++; if (out_data !== 24'h0) $display("FAIL reset_data: got %h want 000000", out_data); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_pass;
    logic [23:0] exp [4];
    exp = '{24'h864606, 24'h874707, 24'h8A4A0A, 24'h8B4B0B};
    q_data.delete(); q_sof.delete();
    send_frame(0, 2'd0, -1, 2'd0);
    repeat (3) @(negedge clk);
    n_checks++; if (q_data.size() != 4) $display("FAIL pass_count: got %0d want 4", q_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== exp[i] || q_sof[i] !== (i == 0))
        $display("FAIL pass_out%0d: got %h sof=%b want %h sof=%b", i, q_data[i], q_sof[i], exp[i], (i == 0));
      else n_pass++;
    end
  endtask

  task automatic test_gauss_sharpen;
    q_data.delete(); q_sof.delete();
    send_frame(1, 2'd2, -1, 2'd0);
    repeat (3) @(negedge clk);
    n_checks++; if (q_data.size() != 4) $display("FAIL gauss_count: got %0d want 4", q_data.size()); else n_pass++;
    for (int i = 0; i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== 24'h808080) $display("FAIL gauss_out%0d: got %h want 808080", i, q_data[i]); else n_pass++;
    end
    q_data.delete(); q_sof.delete();
    send_frame(2, 2'd1, -1, 2'd0);
    repeat (3) @(negedge clk);
    n_checks++; if (q_data.size() != 4) $display("FAIL sharpen_count: got %0d want 4", q_data.size()); else n_pass++;
    for (int i = 0; i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== 24'h101010) $display("FAIL sharpen_out%0d: got %h want 101010", i, q_data[i]); else n_pass++;
    end
  endtask

  task automatic test_edge_clamp;
    logic [23:0] exp_a [4];
    logic [23:0] exp_b [4];
    exp_a = '{24'hFFFFFF, 24'h000000, 24'h000000, 24'h000000};
    exp_b = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    q_data.delete(); q_sof.delete();
    send_frame(3, 2'd3, -1, 2'd0);
    repeat (3) @(negedge clk);
    n_checks++; if (q_data.size() != 4) $display("FAIL edge_hi_count: got %0d want 4", q_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== exp_a[i]) $display("FAIL edge_hi_out%0d: got %h want %h", i, q_data[i], exp_a[i]); else n_pass++;
    end
`ifdef CONV33_SAT_CNT_EN
    n_checks++; if (sat_cnt !== 16'd12) $display("FAIL sat_cnt_hi: got %0d want 12", sat_cnt); else n_pass++;
`endif
    q_data.delete(); q_sof.delete();
    send_frame(4, 2'd3, -1, 2'd0);
    repeat (3) @(negedge clk);
    n_checks++; if (q_data.size() != 4) $display("FAIL edge_lo_count: got %0d want 4", q_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== exp_b[i]) $display("FAIL edge_lo_out%0d: got %h want %h", i, q_data[i], exp_b[i]); else n_pass++;
    end
`ifdef CONV33_SAT_CNT_EN
    n_checks++; if (sat_cnt !== 16'd3) $display("FAIL sat_cnt_lo: got %0d want 3", sat_cnt); else n_pass++;
`endif
  endtask

  task automatic test_backpressure;
    logic [23:0] exp [4];
    logic [23:0] held;
    int n;
    exp = '{24'h864606, 24'h874707, 24'h8A4A0A, 24'h8B4B0B};
    q_data.delete(); q_sof.delete();
    out_ready = 1'b0;
    fork
      send_frame(0, 2'd0, -1, 2'd0);
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        held = out_data;
        n_checks++; if (held !== 24'h864606) $display("FAIL stall_first: got %h want 864606", held); else n_pass++;
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          n_checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held)
            $display("FAIL stall_hold%0d: in_ready=%b valid=%b data=%h want 0 1 %h", i, in_ready, out_valid, out_data, held);
          else n_pass++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (3) @(negedge clk);
    n_checks++; if (q_data.size() != 4) $display("FAIL stall_count: got %0d want 4", q_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== exp[i]) $display("FAIL stall_out%0d: got %h want %h", i, q_data[i], exp[i]); else n_pass++;
    end
  endtask

  task automatic test_mode_latch;
    logic [23:0] exp [4];
    exp = '{24'h151515, 24'h161616, 24'h191919, 24'h1A1A1A};
    q_data.delete(); q_sof.delete();
    send_frame(5, 2'd0, 2, 2'd3);
    repeat (3) @(negedge clk);
    n_checks++; if (q_data.size() != 4) $display("FAIL latch_count: got %0d want 4", q_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== exp[i]) $display("FAIL latch_out%0d: got %h want %h", i, q_data[i], exp[i]); else n_pass++;
    end
    q_data.delete(); q_sof.delete();
    send_frame(5, 2'd3, -1, 2'd0);
    repeat (3) @(negedge clk);
    n_checks++; if (q_data.size() != 4) $display("FAIL newmode_count: got %0d want 4", q_data.size()); else n_pass++;
    for (int i = 0; i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== 24'h000000) $display("FAIL newmode_out%0d: got %h want 000000", i, q_data[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_midframe;
    logic [23:0] exp [4];
    exp = '{24'h864606, 24'h874707, 24'h8A4A0A, 24'h8B4B0B};
    mode = 2'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (r < 3 || c < 3) push(pixel(0, r, c), (r == 0 && c == 0));
      end
    end
    n_checks++; if (out_valid !== 1'b1) $display("FAIL prerst_valid: got %b want 1", out_valid); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_sof !== 1'b0) $display("FAIL rst_async: valid=%b sof=%b want 0 0", out_valid, out_sof); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    q_data.delete(); q_sof.delete();
    send_frame(0, 2'd0, -1, 2'd0);
    repeat (3) @(negedge clk);
    n_checks++; if (q_data.size() != 4) $display("FAIL postrst_count: got %0d want 4", q_data.size()); else n_pass++;
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== exp[i] || q_sof[i] !== (i == 0))
        $display("FAIL postrst_out%0d: got %h sof=%b want %h sof=%b", i, q_data[i], q_sof[i], exp[i], (i == 0));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_gauss_sharpen();
    test_edge_clamp();
    test_backpressure();
    test_mode_latch();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv33_stream.md
CONV33_STREAM -- requirements
Module: conv33_stream

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of independent PIXEL_WIDTH-bit channels packed in one word.
REQ-002 SHALL have parameter PIXEL_WIDTH, default 8, bits per channel.
REQ-003 SHALL have parameter ACCW, default 16, signed accumulator width per channel (minimum PIXEL_WIDTH+5).
REQ-004 SHALL have parameter IMG_W, default 640, pixels per line (minimum 3).
REQ-005 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port mode, input, 2, kernel select: 0=pass, 1=sharpen, 2=gauss, 3=edge.
REQ-008 SHALL have port in_valid, input, 1, input pixel valid.
REQ-009 SHALL have port in_ready, output, 1, input pixel accepted when in_valid && in_ready.
REQ-010 SHALL have port in_sof, input, 1, marks the accepted pixel as row 0, column 0 of a new frame.
REQ-011 SHALL have port in_data, input, NUM_CH*PIXEL_WIDTH, packed channels; channel k at [k*PIXEL_WIDTH +: PIXEL_WIDTH].
REQ-012 SHALL have port out_valid, output, 1, output pixel valid.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts when out_valid && out_ready.
REQ-014 SHALL have port out_sof, output, 1, marks the first output pixel of a frame.
REQ-015 SHALL have port out_data, output, NUM_CH*PIXEL_WIDTH, filtered pixel in the same packing as in_data.

Function
REQ-016 SHALL hold two internal line buffers of IMG_W words and a 3x3 window per channel; an accepted pixel shifts the window one column and writes the line buffers at the current column.
REQ-017 SHALL keep column counter col (0..IMG_W-1, wraps to 0 with row increment) and row counter row (16-bit, saturates at 65535); an accepted pixel with in_sof forces col=0, row=0 for that pixel.
REQ-018 SHALL emit exactly one output per accepted pixel with row>=2 and col>=2, centred on input (row-1, col-1); frame output is (IMG_W-2)x(H-2).
REQ-019 SHALL set out_sof on the output produced from row==2, col==2.
REQ-020 SHALL have a single output register; in_ready = !out_valid || out_ready (combinational).
REQ-021 SHALL present out_valid on the cycle after the accepting edge (latency 1); out_valid and out_data SHALL hold stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid after a handshake unless the same edge accepts a pixel producing a new output.
REQ-023 SHALL latch mode on each in_sof acceptance; mode changes mid-frame SHALL be ignored until the next in_sof.
REQ-024 SHALL compute kernels: pass = centre; sharpen = 5c - N - S - E - W; gauss = (corners + 2*edges + 4*centre) >> 4, truncating; edge = 8c - sum of 8 neighbours.
REQ-025 SHALL treat pixels as unsigned, accumulate signed in ACCW bits, and clamp each channel result to [0, 2^PIXEL_WIDTH-1].
REQ-026 SHALL process all NUM_CH channels identically and independently in the same cycle.

Reset
REQ-027 SHALL, on rst high, force out_valid=0, out_sof=0, out_data=0, col=0, row=0, latched mode=0, and window registers 0, asynchronously; line buffer contents are don't-care.
REQ-028 SHALL, on rst asserted mid-frame, discard the partial frame; after release, no output is produced until row>=2 and col>=2 of the counting restarted by reset or in_sof.

Configuration
REQ-029 SHALL, with macro CONV33_SAT_CNT_EN defined, add output port sat_cnt, 16 bits, counting channel results clamped by REQ-025 (per channel, per output handshake), cleared on in_sof acceptance and reset, saturating at 65535.
REQ-030 SHALL, without CONV33_SAT_CNT_EN, omit sat_cnt and all its logic.

Verification
REQ-031 SHALL check IMG_W=4, NUM_CH=3, mode=0, 4x4 frame with ramp values -> 4 outputs equal to input (1,1),(1,2),(2,1),(2,2), first with out_sof=1.
REQ-032 SHALL check mode=2 on a constant-0x80 frame -> every output 0x808080; mode=1 on constant 0x10 -> 0x10.
REQ-033 SHALL check mode=3 with centre 0xFF, neighbours 0x00 -> 0xFF (clamped 2040); centre 0x00, neighbours 0xFF -> 0x00; sat_cnt increments by 3 per output when enabled.
REQ-034 SHALL check out_ready held low 5 cycles while out_valid=1 -> in_ready=0, out_data stable, no pixel lost or duplicated.
REQ-035 SHALL check mode changed mid-frame -> output kernel unchanged until next in_sof.
REQ-036 SHALL check rst pulsed during row 3 -> out_valid=0 immediately; new frame after release produces correct first output with out_sof=1.
